saber_hit_scanner: RTL and testbench

SABER_HIT_SCANNER -- requirements
Module: saber_hit_scanner

---
 rtl/saber_hit_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_saber_hit_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/saber_hit_scanner.sv
// Segment-versus-box hit scanner: each target box is tested one edge per cycle with exact
// orientation arithmetic, plus endpoint containment on the first step of each box.
module saber_hit_scanner #(
    parameter int NUM_TARGETS = 4,
    parameter int X_W         = 11,
    parameter int Y_W         = 10,
    parameter int EARLY_EXIT  = 0
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic [X_W-1:0]             seg_x0_in,
    input  logic [X_W-1:0]             seg_x1_in,
    input  logic [Y_W-1:0]             seg_y0_in,
    input  logic [Y_W-1:0]             seg_y1_in,
    input  logic [NUM_TARGETS*X_W-1:0] box_xmin_in,
    input  logic [NUM_TARGETS*X_W-1:0] box_xmax_in,
    input  logic [NUM_TARGETS*Y_W-1:0] box_ymin_in,
    input  logic [NUM_TARGETS*Y_W-1:0] box_ymax_in,
    input  logic [NUM_TARGETS-1:0]     target_en_in,
    output logic                       ready_out,
    output logic                       done_out,
    output logic [NUM_TARGETS-1:0]     hit_mask_out,
    output logic                       any_hit_out
);

    localparam int OW = X_W + Y_W + 3;
    localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                     r_state, w_stateNext;
    logic [TW-1:0]              r_tgt;
    logic [1:0]                 r_edge;
    logic [NUM_TARGETS-1:0]     r_hits, w_hitsNext;
    logic [X_W-1:0]             r_x0, r_x1;
    logic [Y_W-1:0]             r_y0, r_y1;
    logic [NUM_TARGETS*X_W-1:0] r_boxXmin, r_boxXmax;
    logic [NUM_TARGETS*Y_W-1:0] r_boxYmin, r_boxYmax;
    logic [NUM_TARGETS-1:0]     r_en;

    logic [X_W-1:0]    w_xmin, w_xmax, w_qx1, w_qx2;
    logic [Y_W-1:0]    w_ymin, w_ymax, w_qy1, w_qy2;
    logic              w_en, w_valid, w_in0, w_in1, w_edgeHit, w_stepHit;
    logic              w_lastStep, w_finish;
    logic signed [OW-1:0] w_d1, w_d2, w_d3, w_d4;

    // Differences are exact in one extra bit, so the cross product can never overflow OW bits.
    function automatic logic signed [OW-1:0] orient(
        input logic [X_W-1:0] ax, input logic [Y_W-1:0] ay,
        input logic [X_W-1:0] bx, input logic [Y_W-1:0] by,
        input logic [X_W-1:0] cx, input logic [Y_W-1:0] cy
    );
        logic signed [X_W:0]  dbx, dcx;
        logic signed [Y_W:0]  dby, dcy;
        logic signed [OW-1:0] ebx, ecx, eby, ecy;
        dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dcx = $signed({1'b0, cx}) - $signed({1'b0, ax});
        dby = $signed({1'b0, by}) - $signed({1'b0, ay});
        dcy = $signed({1'b0, cy}) - $signed({1'b0, ay});
        ebx = {{(OW-X_W-1){dbx[X_W]}}, dbx};
        ecx = {{(OW-X_W-1){dcx[X_W]}}, dcx};
        eby = {{(OW-Y_W-1){dby[Y_W]}}, dby};
        ecy = {{(OW-Y_W-1){dcy[Y_W]}}, dcy};
        return ebx * ecy - eby * ecx;
    endfunction

    function automatic logic notSameSide(input logic signed [OW-1:0] a, input logic signed [OW-1:0] b);
        logic aPos, bPos;
        aPos = !a[OW-1] && (a != '0);
        bPos = !b[OW-1] && (b != '0);
        return !((aPos && bPos) || (a[OW-1] && b[OW-1]));
    endfunction

    always_comb begin
        w_xmin = '0;
        w_xmax = '0;
        w_ymin = '0;
        w_ymax = '0;
        w_en   = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (r_tgt == TW'(i)) begin
                w_xmin = r_boxXmin[i*X_W +: X_W];
                w_xmax = r_boxXmax[i*X_W +: X_W];
                w_ymin = r_boxYmin[i*Y_W +: Y_W];
                w_ymax = r_boxYmax[i*Y_W +: Y_W];
                w_en   = r_en[i];
            end
        end
    end

    // Edges walk the box perimeter: top, right, bottom, left.
    always_comb begin
        w_qx1 = w_xmin;
        w_qy1 = w_ymin;
        w_qx2 = w_xmax;
        w_qy2 = w_ymin;
        case (r_edge)
            2'd1: begin w_qx1 = w_xmax; w_qy1 = w_ymin; w_qx2 = w_xmax; w_qy2 = w_ymax; end
            2'd2: begin w_qx1 = w_xmax; w_qy1 = w_ymax; w_qx2 = w_xmin; w_qy2 = w_ymax; end
            2'd3: begin w_qx1 = w_xmin; w_qy1 = w_ymax; w_qx2 = w_xmin; w_qy2 = w_ymin; end
            default: ;
        endcase
    end

    assign w_d1 = orient(w_qx1, w_qy1, w_qx2, w_qy2, r_x0, r_y0);
    assign w_d2 = orient(w_qx1, w_qy1, w_qx2, w_qy2, r_x1, r_y1);
    assign w_d3 = orient(r_x0, r_y0, r_x1, r_y1, w_qx1, w_qy1);
    assign w_d4 = orient(r_x0, r_y0, r_x1, r_y1, w_qx2, w_qy2);

    assign w_edgeHit = notSameSide(w_d1, w_d2) && notSameSide(w_d3, w_d4)
                       && ((w_d1 | w_d2 | w_d3 | w_d4) != '0);
    assign w_in0     = (w_xmin <= r_x0) && (r_x0 <= w_xmax) && (w_ymin <= r_y0) && (r_y0 <= w_ymax);
    assign w_in1     = (w_xmin <= r_x1) && (r_x1 <= w_xmax) && (w_ymin <= r_y1) && (r_y1 <= w_ymax);
    assign w_valid   = (w_xmin <= w_xmax) && (w_ymin <= w_ymax);
    assign w_stepHit = w_en && w_valid && (w_edgeHit || ((r_edge == 2'd0) && (w_in0 || w_in1)));

    assign w_lastStep = (r_edge == 2'd3) && (r_tgt == TW'(NUM_TARGETS - 1));
    assign w_finish   = w_lastStep || ((EARLY_EXIT != 0) && w_stepHit);

    always_comb begin
        w_hitsNext = r_hits;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (w_stepHit && (r_tgt == TW'(i))) begin
                w_hitsNext[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        ready_out   = 1'b0;
        done_out    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_out = 1'b1;
                if (start_in) begin
                    w_stateNext = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_finish) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                done_out    = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_tgt        <= '0;
            r_edge       <= '0;
            r_hits       <= '0;
            r_x0         <= '0;
            r_x1         <= '0;
            r_y0         <= '0;
            r_y1         <= '0;
            r_boxXmin    <= '0;
            r_boxXmax    <= '0;
            r_boxYmin    <= '0;
            r_boxYmax    <= '0;
            r_en         <= '0;
            hit_mask_out <= '0;
            any_hit_out  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_x0      <= seg_x0_in;
                        r_x1      <= seg_x1_in;
                        r_y0      <= seg_y0_in;
                        r_y1      <= seg_y1_in;
                        r_boxXmin <= box_xmin_in;
                        r_boxXmax <= box_xmax_in;
                        r_boxYmin <= box_ymin_in;
                        r_boxYmax <= box_ymax_in;
                        r_en      <= target_en_in;
                        r_tgt     <= '0;
                        r_edge    <= '0;
                        r_hits    <= '0;
                    end
                end
                S_SCAN: begin
                    r_hits <= w_hitsNext;
                    r_edge <= r_edge + 2'd1;
                    if (r_edge == 2'd3) begin
                        r_tgt <= r_tgt + 1'b1;
                    end
                    if (w_finish) begin
                        hit_mask_out <= w_hitsNext;
                        any_hit_out  <= |w_hitsNext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_saber_hit_scanner.sv
// Directed bench for saber_hit_scanner: one single-target instance and two four-target
// instances (full scan and early exit) share clock, reset, start and segment inputs.
module tb_saber_hit_scanner;

    localparam int XW = 11;
    localparam int YW = 10;

    logic clk, rst_n, start;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [XW-1:0] b1xmin, b1xmax;
    logic [YW-1:0] b1ymin, b1ymax;
    logic [0:0]    b1en;
    logic [4*XW-1:0] b4xmin, b4xmax;
    logic [4*YW-1:0] b4ymin, b4ymax;
    logic [3:0]      b4en;

    logic ready1, done1, any1;
    logic [0:0] mask1;
    logic ready4, done4, any4;
    logic [3:0] mask4;
    logic ready4e, done4e, any4e;
    logic [3:0] mask4e;

    int checkCount = 0;
    int passCount  = 0;
    int doneCyc1, doneCyc4, doneCyc4e, doneCnt1, doneCnt4, doneCnt4e;

    // Single-target vectors: segment, enable, box x bounds (y bounds fixed 100..300), expected bit.
    int vX0 [10] = '{50, 50, 150, 0, 400, 200, 50, 50, 310, 300};
    int vY0 [10] = '{50, 200, 150, 0, 400, 200, 200, 200, 0, 50};
    int vX1 [10] = '{350, 350, 160, 100, 400, 200, 350, 350, 310, 300};
    int vY1 [10] = '{50, 200, 160, 100, 400, 200, 200, 200, 400, 100};
    int vEn [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    int vXmn[10] = '{100, 100, 100, 100, 100, 100, 100, 300, 100, 100};
    int vXmx[10] = '{300, 300, 300, 300, 300, 300, 300, 100, 300, 300};
    int vExp[10] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 1};

    saber_hit_scanner #(.NUM_TARGETS(1), .X_W(XW), .Y_W(YW), .EARLY_EXIT(0)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .seg_x0_in(x0), .seg_x1_in(x1), .seg_y0_in(y0), .seg_y1_in(y1),
        .box_xmin_in(b1xmin), .box_xmax_in(b1xmax), .box_ymin_in(b1ymin), .box_ymax_in(b1ymax),
        .target_en_in(b1en),
        .ready_out(ready1), .done_out(done1), .hit_mask_out(mask1), .any_hit_out(any1)
    );

    saber_hit_scanner #(.NUM_TARGETS(4), .X_W(XW), .Y_W(YW), .EARLY_EXIT(0)) u_dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .seg_x0_in(x0), .seg_x1_in(x1), .seg_y0_in(y0), .seg_y1_in(y1),
        .box_xmin_in(b4xmin), .box_xmax_in(b4xmax), .box_ymin_in(b4ymin), .box_ymax_in(b4ymax),
        .target_en_in(b4en),
        .ready_out(ready4), .done_out(done4), .hit_mask_out(mask4), .any_hit_out(any4)
    );

    saber_hit_scanner #(.NUM_TARGETS(4), .X_W(XW), .Y_W(YW), .EARLY_EXIT(1)) u_dut4e (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .seg_x0_in(x0), .seg_x1_in(x1), .seg_y0_in(y0), .seg_y1_in(y1),
        .box_xmin_in(b4xmin), .box_xmax_in(b4xmax), .box_ymin_in(b4ymin), .box_ymax_in(b4ymax),
        .target_en_in(b4en),
        .ready_out(ready4e), .done_out(done4e), .hit_mask_out(mask4e), .any_hit_out(any4e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setSeg(input int ax, input int ay, input int bx, input int by);
        x0 = XW'(ax);
        y0 = YW'(ay);
        x1 = XW'(bx);
        y1 = YW'(by);
    endtask

    task automatic setBox4(input int i, input int xmn, input int xmx, input int ymn, input int ymx);
        b4xmin[i*XW +: XW] = XW'(xmn);
        b4xmax[i*XW +: XW] = XW'(xmx);
        b4ymin[i*YW +: YW] = YW'(ymn);
        b4ymax[i*YW +: YW] = YW'(ymx);
    endtask

    // Boxes 2 and 3 are crossed by y=200; box 2 holds the left endpoint so it hits on its first step.
    task automatic setMultiBoxes();
        setBox4(0, 400, 500, 400, 500);
        setBox4(1, 10, 40, 10, 40);
        setBox4(2, 0, 100, 100, 300);
        setBox4(3, 200, 250, 0, 400);
    endtask

    // Waits for all instances idle, issues one accept and records done timing over 24 cycles.
    task automatic runScan(input bit holdStart, input bit scramble);
        int w;
        w = 0;
        while (!(ready1 && ready4 && ready4e) && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        checkCount++;
        if (!(ready1 && ready4 && ready4e))
            $display("[TB] FAIL ready_wait: ready1=%b ready4=%b ready4e=%b, required all 1", ready1, ready4, ready4e);
        else passCount++;
        start = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        if (scramble) begin
            setSeg(0, 0, 0, 0);
            b1en = 1'b0;
            b1xmin = XW'(300);
            b1xmax = XW'(100);
            b4en = 4'b0000;
        end
        doneCyc1 = 0; doneCyc4 = 0; doneCyc4e = 0;
        doneCnt1 = 0; doneCnt4 = 0; doneCnt4e = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (done1)  begin if (doneCyc1 == 0)  doneCyc1 = cyc;  doneCnt1++;  end
            if (done4)  begin if (doneCyc4 == 0)  doneCyc4 = cyc;  doneCnt4++;  end
            if (done4e) begin if (doneCyc4e == 0) doneCyc4e = cyc; doneCnt4e++; end
            if (cyc < 24) begin @(posedge clk); #1; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (ready1 !== 1'b1) $display("[TB] FAIL reset_ready1: got %b required 1", ready1); else passCount++;
        checkCount++; if (done1 !== 1'b0) $display("[TB] FAIL reset_done1: got %b required 0", done1); else passCount++;
        checkCount++; if (mask1 !== 1'b0 || any1 !== 1'b0) $display("[TB] FAIL reset_mask1: got %b/%b required 0/0", mask1, any1); else passCount++;
        checkCount++; if (ready4 !== 1'b1 || done4 !== 1'b0) $display("[TB] FAIL reset_ctrl4: got ready=%b done=%b required 1/0", ready4, done4); else passCount++;
        checkCount++; if (mask4 !== 4'b0 || any4 !== 1'b0) $display("[TB] FAIL reset_mask4: got %b/%b required 0000/0", mask4, any4); else passCount++;
        checkCount++; if (mask4e !== 4'b0 || ready4e !== 1'b1) $display("[TB] FAIL reset_4e: got mask=%b ready=%b required 0000/1", mask4e, ready4e); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_target();
        for (int v = 0; v < 10; v++) begin
            setSeg(vX0[v], vY0[v], vX1[v], vY1[v]);
            b1en   = 1'(vEn[v]);
            b1xmin = XW'(vXmn[v]);
            b1xmax = XW'(vXmx[v]);
            b1ymin = YW'(100);
            b1ymax = YW'(300);
            runScan(1'b0, 1'b0);
            checkCount++; if (mask1 !== 1'(vExp[v])) $display("[TB] FAIL single[%0d]_mask: got %b required %b", v, mask1, 1'(vExp[v])); else passCount++;
            checkCount++; if (any1 !== 1'(vExp[v])) $display("[TB] FAIL single[%0d]_any: got %b required %b", v, any1, 1'(vExp[v])); else passCount++;
            checkCount++; if (doneCyc1 != 5) $display("[TB] FAIL single[%0d]_latency: got cycle %0d required 5", v, doneCyc1); else passCount++;
        end
    endtask

    task automatic test_multi_target();
        logic [3:0] enTab  [3] = '{4'b1111, 4'b1011, 4'b0000};
        logic [3:0] expFull[3] = '{4'b1100, 4'b1000, 4'b0000};
        logic [3:0] expEe  [3] = '{4'b0100, 4'b1000, 4'b0000};
        int         cycEe  [3] = '{10, 15, 17};
        setMultiBoxes();
        setSeg(50, 200, 350, 200);
        for (int t = 0; t < 3; t++) begin
            b4en = enTab[t];
            runScan(1'b0, 1'b0);
            checkCount++; if (mask4 !== expFull[t]) $display("[TB] FAIL multi[%0d]_mask: got %b required %b", t, mask4, expFull[t]); else passCount++;
            checkCount++; if (any4 !== (expFull[t] != 4'b0)) $display("[TB] FAIL multi[%0d]_any: got %b required %b", t, any4, expFull[t] != 4'b0); else passCount++;
            checkCount++; if (doneCyc4 != 17) $display("[TB] FAIL multi[%0d]_latency: got cycle %0d required 17", t, doneCyc4); else passCount++;
            checkCount++; if (mask4e !== expEe[t]) $display("[TB] FAIL early[%0d]_mask: got %b required %b", t, mask4e, expEe[t]); else passCount++;
            checkCount++; if (doneCyc4e != cycEe[t]) $display("[TB] FAIL early[%0d]_latency: got cycle %0d required %0d", t, doneCyc4e, cycEe[t]); else passCount++;
        end
    endtask

    task automatic test_input_capture();
        setMultiBoxes();
        setSeg(50, 200, 350, 200);
        b4en = 4'b1111;
        b1en = 1'b1;
        b1xmin = XW'(100); b1xmax = XW'(300);
        b1ymin = YW'(100); b1ymax = YW'(300);
        runScan(1'b0, 1'b1);
        checkCount++; if (mask1 !== 1'b1) $display("[TB] FAIL capture_mask1: got %b required 1", mask1); else passCount++;
        checkCount++; if (mask4 !== 4'b1100) $display("[TB] FAIL capture_mask4: got %b required 1100", mask4); else passCount++;
        checkCount++; if (mask4e !== 4'b0100) $display("[TB] FAIL capture_mask4e: got %b required 0100", mask4e); else passCount++;
    endtask

    task automatic test_back_to_back();
        setMultiBoxes();
        setSeg(50, 200, 350, 200);
        b4en = 4'b1111;
        b1en = 1'b1;
        b1xmin = XW'(100); b1xmax = XW'(300);
        runScan(1'b1, 1'b0);
        checkCount++; if (doneCnt1 != 4) $display("[TB] FAIL hold_pulses1: got %0d required 4", doneCnt1); else passCount++;
        checkCount++; if (doneCnt4 != 1) $display("[TB] FAIL hold_pulses4: got %0d required 1", doneCnt4); else passCount++;
        checkCount++; if (doneCnt4e != 2) $display("[TB] FAIL hold_pulses4e: got %0d required 2", doneCnt4e); else passCount++;
        checkCount++; if (doneCyc1 != 5) $display("[TB] FAIL hold_latency1: got cycle %0d required 5", doneCyc1); else passCount++;
        checkCount++; if (doneCyc4 != 17) $display("[TB] FAIL hold_latency4: got cycle %0d required 17", doneCyc4); else passCount++;
    endtask

    task automatic test_reset_midscan();
        int w;
        w = 0;
        while (!(ready1 && ready4 && ready4e) && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        checkCount++;
        if (!(ready4 && ready4e)) $display("[TB] FAIL midscan_ready: got %b/%b required 1/1", ready4, ready4e); else passCount++;
        setMultiBoxes();
        setSeg(50, 50, 350, 50);
        b4en = 4'b1111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checkCount++; if (mask4 !== 4'b1100) $display("[TB] FAIL midscan_hold4: got %b required 1100", mask4); else passCount++;
        checkCount++; if (ready4 !== 1'b0 || done4 !== 1'b0) $display("[TB] FAIL midscan_busy4: got ready=%b done=%b required 0/0", ready4, done4); else passCount++;
        rst_n = 1'b0;
        #1;
        checkCount++; if (ready4 !== 1'b1 || done4 !== 1'b0) $display("[TB] FAIL abort_ctrl4: got ready=%b done=%b required 1/0", ready4, done4); else passCount++;
        checkCount++; if (mask4 !== 4'b0 || any4 !== 1'b0) $display("[TB] FAIL abort_mask4: got %b/%b required 0000/0", mask4, any4); else passCount++;
        checkCount++; if (mask4e !== 4'b0 || any4e !== 1'b0) $display("[TB] FAIL abort_mask4e: got %b/%b required 0000/0", mask4e, any4e); else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        runScan(1'b0, 1'b0);
        checkCount++; if (mask4 !== 4'b1000) $display("[TB] FAIL rerun_mask4: got %b required 1000", mask4); else passCount++;
        checkCount++; if (doneCyc4 != 17) $display("[TB] FAIL rerun_latency4: got cycle %0d required 17", doneCyc4); else passCount++;
        checkCount++; if (mask4e !== 4'b1000) $display("[TB] FAIL rerun_mask4e: got %b required 1000", mask4e); else passCount++;
        checkCount++; if (doneCyc4e != 15) $display("[TB] FAIL rerun_latency4e: got cycle %0d required 15", doneCyc4e); else passCount++;
        checkCount++; if (mask1 !== 1'b0 || doneCyc1 != 5) $display("[TB] FAIL rerun_dut1: got mask=%b cycle %0d required 0 / 5", mask1, doneCyc1); else passCount++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        setSeg(0, 0, 0, 0);
        b1xmin = '0; b1xmax = '0; b1ymin = '0; b1ymax = '0; b1en = '0;
        b4xmin = '0; b4xmax = '0; b4ymin = '0; b4ymax = '0; b4en = '0;
        test_reset();
        test_single_target();
        test_multi_target();
        test_input_capture();
        test_back_to_back();
        test_reset_midscan();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
